// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regfile_pkg;
  localparam int ADDR_W      = 4;
  localparam int DATA_W      = 32;
  localparam int NUM_REGS    = 16;
  localparam int NUM_REQ_DEF = 3;

  typedef enum logic [1:0] {ARB, DRAIN, CLEAR} arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side handshake and register-file write port of regfile_wr_arbiter.
// Handshake: a transfer on requester i happens in a cycle where req_valid[i] && req_ready[i];
// the requester holds req_rd/req_data stable while req_valid is high and no transfer has happened.
interface regfile_wr_arbiter_if
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_rd;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      clear_req;
  logic                      clear_busy;
  logic                      wen;
  logic [ADDR_W-1:0]         write_Rd;
  logic [DATA_W-1:0]         write_data;

  modport master (
    output req_valid, req_rd, req_data, clear_req,
    input  req_ready, clear_busy, wen, write_Rd, write_data
  );

  modport slave (
    input  req_valid, req_rd, req_data, clear_req,
    output req_ready, clear_busy, wen, write_Rd, write_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after (ptr + 1) mod N.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file write port between NUM_REQ one-entry slots and runs the R1..R(NUM_REGS-1) clear.
// Define REGFILE_ARB_PRIO_EN to give requester 0 strict priority over a round-robin among the others.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_wr_arbiter_if.slave bus,
  output arb_state_t          state_dbg
);
  localparam int IDX_W = idx_w(NUM_REQ);

  arb_state_t          state, state_nxt;
  logic [NUM_REQ-1:0]  slot_v, slot_v_nxt, accept, fill;
  logic [NUM_REQ-1:0]  arb_req, arb_gnt, gnt, req_ready_c;
  logic [ADDR_W-1:0]   slot_rd   [NUM_REQ];
  logic [DATA_W-1:0]   slot_data [NUM_REQ];
  logic [IDX_W-1:0]    ptr, arb_idx, gnt_idx;
  logic                arb_any, gnt_any, ptr_upd;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                wen_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [DATA_W-1:0]   data_q;

`ifdef REGFILE_ARB_PRIO_EN
  // Slot 0 is handled outside the rotation, so the shared picker only sees 1..NUM_REQ-1.
  assign arb_req = slot_v & ~NUM_REQ'(1);
`else
  assign arb_req = slot_v;
`endif

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req (arb_req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    gnt     = '0;
    gnt_idx = arb_idx;
    gnt_any = 1'b0;
    ptr_upd = 1'b0;
    if (state != CLEAR) begin
      gnt     = arb_gnt;
      gnt_any = arb_any;
      ptr_upd = arb_any;
`ifdef REGFILE_ARB_PRIO_EN
      if (slot_v[0]) begin
        gnt     = NUM_REQ'(1);
        gnt_idx = '0;
        gnt_any = 1'b1;
        ptr_upd = 1'b0;
      end
`endif
    end
  end

  assign req_ready_c = (state == ARB) ? (~slot_v | gnt) : '0;
  assign accept      = bus.req_valid & req_ready_c;

  // A transfer to R0 completes the handshake but never occupies the slot.
  always_comb begin
    fill = '0;
    for (int i = 0; i < NUM_REQ; i++)
      fill[i] = accept[i] && (bus.req_rd[i*ADDR_W +: ADDR_W] != '0);
  end

  assign slot_v_nxt = (slot_v & ~gnt) | fill;

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (bus.clear_req) state_nxt = (|slot_v_nxt) ? DRAIN : CLEAR;
      DRAIN:   if (slot_v_nxt == '0) state_nxt = CLEAR;
      CLEAR:   if (clr_cnt == ADDR_W'(NUM_REGS - 1)) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ARB;
      slot_v  <= '0;
      ptr     <= '0;
      clr_cnt <= '0;
      wen_q   <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      state  <= state_nxt;
      slot_v <= slot_v_nxt;
      if (ptr_upd) ptr <= arb_idx;
      if (state != CLEAR && state_nxt == CLEAR) clr_cnt <= ADDR_W'(1);
      else if (state == CLEAR)                  clr_cnt <= clr_cnt + 1'b1;
      if (state == CLEAR) begin
        wen_q  <= 1'b1;
        rd_q   <= clr_cnt;
        data_q <= '0;
      end else if (gnt_any) begin
        wen_q  <= 1'b1;
        rd_q   <= slot_rd[gnt_idx];
        data_q <= slot_data[gnt_idx];
      end else begin
        wen_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (fill[i]) begin
        slot_rd[i]   <= bus.req_rd[i*ADDR_W +: ADDR_W];
        slot_data[i] <= bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.clear_busy = (state != ARB);
  assign bus.wen        = wen_q;
  assign bus.write_Rd   = rd_q;
  assign bus.write_data = data_q;
  assign state_dbg      = state;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_regfile_wr_arbiter;
  import regfile_pkg::*;
  localparam int N = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.NUM_REQ(N)) bus();
  arb_state_t state_dbg;

  regfile_wr_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // reference model: pending writes per slot, last winners, clear progress
  arb_state_t          m_state;
  bit                  m_v    [N];
  logic [ADDR_W-1:0]   m_rd   [N];
  logic [DATA_W-1:0]   m_data [N];
  bit                  m_acc  [N];
  int                  m_last, m_last_hi, m_cnt;
  logic [ADDR_W+DATA_W-1:0] m_hold;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit collect = 1'b0;
  int n_xfer  = 0;
  logic [DATA_W-1:0] obs_q[$];
  logic [DATA_W-1:0] first_data [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = ARB;
    m_last = 0; m_last_hi = 0; m_cnt = 0;
    m_hold = '0;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 1'b0; m_acc[i] = 1'b0;
    end
  endtask

  function automatic int pick();
`ifdef REGFILE_ARB_PRIO_EN
    if (m_v[0]) return 0;
    for (int k = 1; k <= N; k++) begin
      int j = (m_last_hi + k) % N;
      if (j != 0 && m_v[j]) return j;
    end
`else
    for (int k = 1; k <= N; k++) begin
      int j = (m_last + k) % N;
      if (m_v[j]) return j;
    end
`endif
    return -1;
  endfunction

  task automatic check_outputs();
    int g;
    logic [N-1:0] er;
    g = (m_state == CLEAR) ? -1 : pick();
    for (int i = 0; i < N; i++) er[i] = (m_state == ARB) && (!m_v[i] || g == i);
    check("req_ready", bus.req_ready, er);
    check("clear_busy", bus.clear_busy, m_state != ARB);
    check("state", state_dbg, m_state);
    if (exp_q.size() > 0) begin
      check("wen", bus.wen, 1);
      m_hold = exp_q.pop_front();
    end else begin
      check("wen", bus.wen, 0);
    end
    check("write_port", {bus.write_Rd, bus.write_data}, m_hold);
  endtask

  task automatic advance();
    int g;
    bit any;
    if (!rst_n) begin
      model_reset();
      return;
    end
    g = (m_state == CLEAR) ? -1 : pick();
    for (int i = 0; i < N; i++)
      m_acc[i] = bus.req_valid[i] && (m_state == ARB) && (!m_v[i] || g == i);
    if (m_state == CLEAR) begin
      exp_q.push_back({ADDR_W'(m_cnt), DATA_W'(0)});
    end else if (g >= 0) begin
      exp_q.push_back({m_rd[g], m_data[g]});
      m_v[g] = 1'b0;
`ifdef REGFILE_ARB_PRIO_EN
      if (g != 0) m_last_hi = g;
`else
      m_last = g;
`endif
    end
    for (int i = 0; i < N; i++) begin
      if (m_acc[i]) begin
        if (collect) n_xfer++;
        if (bus.req_rd[i*ADDR_W +: ADDR_W] != '0) begin
          m_v[i]    = 1'b1;
          m_rd[i]   = bus.req_rd[i*ADDR_W +: ADDR_W];
          m_data[i] = bus.req_data[i*DATA_W +: DATA_W];
        end else if (collect) begin
          n_xfer--;
        end
      end
    end
    any = 1'b0;
    for (int i = 0; i < N; i++) any |= m_v[i];
    case (m_state)
      ARB:   if (bus.clear_req) begin
               if (any) m_state = DRAIN;
               else begin m_state = CLEAR; m_cnt = 1; end
             end
      DRAIN: if (!any) begin m_state = CLEAR; m_cnt = 1; end
      default: if (m_cnt == NUM_REGS - 1) m_state = ARB; else m_cnt++;
    endcase
  endtask

  // one clock: compare at negedge, advance model, resume 1 ns after posedge
  task automatic step();
    @(negedge clk);
    check_outputs();
    if (collect && bus.wen) obs_q.push_back(bus.write_data);
    advance();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic set_req(input int i, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    bus.req_valid[i] = 1'b1;
    bus.req_rd[i*ADDR_W +: ADDR_W] = rd;
    bus.req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic drive_rand(input logic [N-1:0] en, input int pct, input bit allow_r0);
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] && !m_acc[i]) continue;
      if (en[i] && $urandom_range(99) < pct)
        set_req(i, allow_r0 ? ADDR_W'($urandom_range(NUM_REGS - 1))
                            : ADDR_W'($urandom_range(NUM_REGS - 1, 1)), $urandom);
      else
        bus.req_valid[i] = 1'b0;
    end
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      drive_rand('0, 0, 1'b0);
      step();
    end
  endtask

  initial begin
    int zeros;
    bit reached;
    bus.req_valid = '0;
    bus.req_rd    = '0;
    bus.req_data  = '0;
    bus.clear_req = 1'b0;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_wen", bus.wen, 0);
    check("rst_write_Rd", bus.write_Rd, 0);
    check("rst_write_data", bus.write_data, 0);
    check("rst_clear_busy", bus.clear_busy, 0);
    check("rst_ready", bus.req_ready, 3'b111);

    // single write, visible two cycles after the transfer
    set_req(0, 4'd5, 32'hDEADBEEF);
    step();
    bus.req_valid[0] = 1'b0;
    step();
    check("single_wen", bus.wen, 1);
    check("single_rd", bus.write_Rd, 5);
    check("single_data", bus.write_data, 32'hDEADBEEF);
    idle(3);

    // requester 2 wins once so the rotation restarts at requester 0
    set_req(2, 4'd3, 32'h0000_0033);
    step();
    idle(4);

    // fairness: all requesters valid every cycle
    collect = 1'b1;
    n_xfer = 0;
    obs_q.delete();
    for (int i = 0; i < N; i++) begin
      first_data[i] = $urandom;
      set_req(i, ADDR_W'(i + 1), first_data[i]);
    end
    step();
    for (int c = 0; c < 11; c++) begin
      drive_rand('1, 100, 1'b0);
      step();
    end
    idle(8);
    collect = 1'b0;
    check("fair_count", obs_q.size(), n_xfer);
    if (obs_q.size() >= 3) begin
      check("fair_order0", obs_q[0], first_data[0]);
      check("fair_order1", obs_q[1], first_data[1]);
      check("fair_order2", obs_q[2], first_data[2]);
    end else begin
      check("fair_too_few", obs_q.size(), 3);
    end

    // R0 write is accepted and dropped
    set_req(1, 4'd0, 32'h0000_1234);
    check("r0_ready", bus.req_ready[1], 1);
    step();
    bus.req_valid[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("r0_wen", bus.wen, 0);
    end

    // clear with slots 0 and 2 pending
    set_req(0, 4'd4, 32'hAAAA_0001);
    set_req(2, 4'd9, 32'hBBBB_0002);
    step();
    bus.req_valid = '0;
    bus.clear_req = 1'b1;
    collect = 1'b1;
    obs_q.delete();
    step();
    bus.clear_req = 1'b0;
    for (int c = 0; c < 24; c++) step();
    collect = 1'b0;
    zeros = 0;
    foreach (obs_q[k]) if (obs_q[k] == '0) zeros++;
    check("clr_writes", obs_q.size(), 17);
    check("clr_zero_writes", zeros, 15);
    check("clr_back_ready", bus.req_ready, 3'b111);

    // reset while the clear sequence is at R7
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 20 && !reached; c++) begin
      if (m_state == CLEAR && m_cnt == 7) reached = 1'b1;
      else step();
    end
    check("midclr_reached", reached, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midclr_wen", bus.wen, 0);
    check("midclr_busy", bus.clear_busy, 0);
    check("midclr_ready", bus.req_ready, 3'b111);
    idle(2);

    // random traffic with occasional clears
    for (int c = 0; c < 400; c++) begin
      drive_rand('1, 60, 1'b1);
      bus.clear_req = ($urandom_range(49) == 0);
      step();
    end
    bus.clear_req = 1'b0;
    idle(30);

`ifdef REGFILE_ARB_PRIO_EN
    for (int c = 0; c < 10; c++) begin
      drive_rand('1, 100, 1'b0);
      step();
    end
    for (int c = 0; c < 10; c++) begin
      drive_rand(3'b110, 100, 1'b0);
      step();
    end
    idle(8);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
